// File: rtl/pc_fetch_ctrl_if.sv
// Signal bundle between the IF-stage PC sequencer and its surroundings:
// PC register, hazard unit, EX redirect, trap logic and instruction memory.
interface pc_fetch_ctrl_if;
  logic [31:0] pc;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_valid;
  logic [31:0] trap_vector;
  logic        imem_ready;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        fetch_valid;
  logic        flush_d;
  logic        misaligned;

  // Environment side: supplies the PC and control requests, consumes the sequencer outputs.
  modport master (
    output pc, stall_f, redirect_valid, redirect_pc, trap_valid, trap_vector, imem_ready,
    input  pc_next, imem_req, fetch_valid, flush_d, misaligned
  );

  // Sequencer side.
  modport slave (
    input  pc, stall_f, redirect_valid, redirect_pc, trap_valid, trap_vector, imem_ready,
    output pc_next, imem_req, fetch_valid, flush_d, misaligned
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// IF-stage program-counter sequencer: picks pc_next from reset/trap/redirect/stall/wait/+4
// and runs the req/ready handshake with instruction memory, parking late redirects.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned PC_STEP      = 4
) (
  input  logic             clk,
  input  logic             rst,
  pc_fetch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    WAIT_MEM   = 2'd2,
    REDIR_PEND = 2'd3
  } state_e;

  localparam logic [31:0] STEP = 32'(PC_STEP);

  state_e      state_q, state_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic [31:0] pc_seq;
  logic        redir_any;
  logic [31:0] redir_tgt;
  logic [31:0] pend_eff;

  logic [31:0] pc_next_c;
  logic        imem_req_c;
  logic        fetch_valid_c;
  logic        flush_d_c;
  logic        misaligned_c;

  // Trap beats redirect whenever both arrive together.
  assign pc_seq    = bus.pc + STEP;
  assign redir_any = bus.trap_valid | bus.redirect_valid;
  assign redir_tgt = bus.trap_valid ? bus.trap_vector : bus.redirect_pc;
  // A trap arriving in the completion cycle of a parked redirect still wins.
  assign pend_eff  = bus.trap_valid ? bus.trap_vector : pend_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pend_pc_d     = pend_pc_q;
    pc_next_c     = bus.pc;
    imem_req_c    = 1'b0;
    fetch_valid_c = 1'b0;
    flush_d_c     = 1'b0;
    misaligned_c  = 1'b0;

    if (rst) begin
      pc_next_c = RESET_VECTOR;
    end else begin
      unique case (state_q)
        BOOT: begin
          pc_next_c = RESET_VECTOR;
          state_d   = RUN;
        end

        RUN: begin
          imem_req_c = ~bus.stall_f | redir_any;
          if (redir_any) begin
            pc_next_c    = {redir_tgt[31:2], 2'b00};
            misaligned_c = |redir_tgt[1:0];
            flush_d_c    = 1'b1;
          end else if (bus.stall_f) begin
            pc_next_c = bus.pc;
          end else if (bus.imem_ready) begin
            fetch_valid_c = 1'b1;
            pc_next_c     = pc_seq;
          end else begin
            state_d = WAIT_MEM;
          end
        end

        WAIT_MEM: begin
          imem_req_c = 1'b1;
          if (redir_any) begin
            flush_d_c = 1'b1;
            if (bus.imem_ready) begin
              // Stale fetch lands now: drop its data and jump straight away.
              pc_next_c    = {redir_tgt[31:2], 2'b00};
              misaligned_c = |redir_tgt[1:0];
              state_d      = RUN;
            end else begin
              pend_pc_d = redir_tgt;
              state_d   = REDIR_PEND;
            end
          end else if (bus.imem_ready) begin
            state_d = RUN;
            if (!bus.stall_f) begin
              fetch_valid_c = 1'b1;
              pc_next_c     = pc_seq;
            end
          end
        end

        REDIR_PEND: begin
          imem_req_c = 1'b1;
          if (bus.trap_valid) begin
            pend_pc_d = bus.trap_vector;
          end
          if (bus.imem_ready) begin
            pc_next_c    = {pend_eff[31:2], 2'b00};
            misaligned_c = |pend_eff[1:0];
            state_d      = RUN;
          end
        end

        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  assign bus.pc_next     = pc_next_c;
  assign bus.imem_req    = imem_req_c;
  assign bus.fetch_valid = fetch_valid_c;
  assign bus.flush_d     = flush_d_c;
  assign bus.misaligned  = misaligned_c;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: a local PC register closes the loop, each step
// drives inputs after the rising edge and checks outputs on the falling edge.
module tb_pc_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_r = 32'h0;
  int          errors = 0;
  int          checks = 0;

  pc_fetch_ctrl_if bus ();

  pc_fetch_ctrl #(
    .RESET_VECTOR (32'h0000_0000),
    .PC_STEP      (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // The PC register loads pc_next unconditionally every cycle.
  always_ff @(posedge clk) pc_r <= bus.pc_next;
  assign bus.pc = pc_r;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic rv, input logic [31:0] rp,
                       input logic tv, input logic [31:0] tvec, input logic rdy);
    rst                = r;
    bus.stall_f        = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rp;
    bus.trap_valid     = tv;
    bus.trap_vector    = tvec;
    bus.imem_ready     = rdy;
    @(negedge clk);
  endtask

  task automatic outs(input string tag, input logic [31:0] pcn, input logic req,
                      input logic fv, input logic fl, input logic mis);
    chk({tag, ".pc_next"},     bus.pc_next,     pcn);
    chk({tag, ".imem_req"},    bus.imem_req,    {31'b0, req});
    chk({tag, ".fetch_valid"}, bus.fetch_valid, {31'b0, fv});
    chk({tag, ".flush_d"},     bus.flush_d,     {31'b0, fl});
    chk({tag, ".misaligned"},  bus.misaligned,  {31'b0, mis});
    $display("step %-12s pc=%h pc_next=%h req=%b fv=%b flush=%b mis=%b", tag, bus.pc,
             bus.pc_next, bus.imem_req, bus.fetch_valid, bus.flush_d, bus.misaligned);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset for two cycles with memory always ready.
    drive(1, 0, 0, 32'h0, 0, 32'h0, 1); outs("rst0", 32'h0, 0, 0, 0, 0);
    drive(1, 0, 0, 32'h0, 0, 32'h0, 1); outs("rst1", 32'h0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("boot", 32'h0, 0, 0, 0, 0);
    chk("pc_after_boot", pc_r, 32'h0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("seq0", 32'h4, 1, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("seq4", 32'h8, 1, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("seq8", 32'hC, 1, 1, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("seqC", 32'h10, 1, 1, 0, 0);

    // Redirect in RUN.
    drive(0, 0, 1, 32'h200, 0, 32'h0, 1); outs("redir", 32'h200, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);   outs("tgt200", 32'h204, 1, 1, 0, 0);

    // Misaligned redirect target.
    drive(0, 0, 1, 32'h202, 0, 32'h0, 1); outs("misal", 32'h200, 1, 0, 1, 1);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);   outs("misal_end", 32'h204, 1, 1, 0, 0);

    // Trap and redirect together: trap wins.
    drive(0, 0, 1, 32'h300, 1, 32'h100, 1); outs("trap_vs_rd", 32'h100, 1, 0, 1, 0);
    drive(0, 0, 1, 32'h20, 0, 32'h0, 1);    outs("to20", 32'h20, 1, 0, 1, 0);

    // Hazard stall for three cycles.
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1); outs("stall0", 32'h20, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1); outs("stall1", 32'h20, 0, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1); outs("stall2", 32'h20, 0, 0, 0, 0);
    // Stall arriving as the outstanding fetch completes: same pc refetched.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0); outs("wait20", 32'h20, 1, 0, 0, 0);
    drive(0, 1, 0, 32'h0, 0, 32'h0, 1); outs("stall_done", 32'h20, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("refetch20", 32'h24, 1, 1, 0, 0);

    // Memory wait with a redirect parked until the stale fetch completes.
    drive(0, 0, 1, 32'h40, 0, 32'h0, 1); outs("to40", 32'h40, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);  outs("w40_0", 32'h40, 1, 0, 0, 0);
    drive(0, 0, 1, 32'h80, 0, 32'h0, 0); outs("w40_redir", 32'h40, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);  outs("pend_hold", 32'h40, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);  outs("pend_done", 32'h80, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);  outs("tgt80", 32'h84, 1, 1, 0, 0);

    // Redirect in WAIT_MEM coinciding with completion: taken immediately, misaligned.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);   outs("w84", 32'h84, 1, 0, 0, 0);
    drive(0, 0, 1, 32'h302, 0, 32'h0, 1); outs("w84_redir", 32'h300, 1, 0, 1, 1);

    // Trap overrides a parked redirect; later redirects are ignored.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0);     outs("w300", 32'h300, 1, 0, 0, 0);
    drive(0, 0, 1, 32'h500, 0, 32'h0, 0);   outs("w300_redir", 32'h300, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h0, 1, 32'h600, 0);   outs("pend_trap", 32'h300, 1, 0, 0, 0);
    drive(0, 0, 1, 32'h700, 0, 32'h0, 0);   outs("pend_ign", 32'h300, 1, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);     outs("pend_trap_done", 32'h600, 1, 0, 0, 0);

    // Sequential wrap at the top of the address space.
    drive(0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0, 1); outs("to_top", 32'hFFFF_FFFC, 1, 0, 1, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1);         outs("wrap", 32'h0, 1, 1, 0, 0);

    // Reset in the middle of an outstanding fetch.
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0); outs("w0", 32'h0, 1, 0, 0, 0);
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0); outs("rst_mid", 32'h0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("reboot", 32'h0, 0, 0, 0, 0);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1); outs("rerun", 32'h4, 1, 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
